spdif_frame_fifo: RTL and testbench

Consumes decoded subframes from the S/PDIF decoder (28-bit package, 3-bit preamble, enable strobe) in the clk6 domain. Pairs channel-A/channel-B subframes into stereo frames and checks parity on each subframe. Tracks the frame position within the 192-frame channel-status block. Buffers frames in a synchronous FIFO with a valid/ready read port for the downstream register/DSP interface.

---
 rtl/spdif_frame_fifo_pkg.sv | 45 ++++
 rtl/spdif_frame_fifo_if.sv | 25 ++
 rtl/spdif_frame_fifo_sync_fifo.sv | 56 +++++
 rtl/spdif_frame_fifo.sv | 169 ++++++++++++++++
 tb/tb_spdif_frame_fifo.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spdif_frame_fifo_pkg.sv
// Shared S/PDIF subframe definitions: preamble codes, package field indices,
// block length and the stereo frame record stored in the frame FIFO.
package spdif_frame_fifo_pkg;

  localparam logic [2:0] PRE_B = 3'b001;
  localparam logic [2:0] PRE_M = 3'b010;
  localparam logic [2:0] PRE_W = 3'b100;

  localparam int PKG_W    = 28;
  localparam int SAMPLE_W = 24;
  localparam int STATUS_W = 9;
  localparam int IDX_W    = 8;

  // Bit positions inside the 28-bit package (subframe bits 4..31)
  localparam int AUX_LSB     = 0;
  localparam int AUX_MSB     = 3;
  localparam int AUDIO_LSB   = 4;
  localparam int AUDIO_MSB   = 23;
  localparam int VALIDITY    = 24;
  localparam int USER_DATA   = 25;
  localparam int CHNL_STATUS = 26;
  localparam int PARITY      = 27;

  localparam int BLOCK_LEN = 192;

  typedef enum logic {
    ST_IDLE,
    ST_HAVE_A
  } fsm_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
    logic [STATUS_W-1:0] status;
    logic [IDX_W-1:0]    idx;
  } frame_t;

  localparam int FRAME_W = $bits(frame_t);

  // Even parity over bits 4..31: a set result flags a corrupted subframe
  function automatic logic sub_perr(input logic [PKG_W-1:0] p);
    return p[PARITY] ^ (^p[CHNL_STATUS:0]);
  endfunction

endpackage

// File: rtl/spdif_frame_fifo_if.sv
// Subframe input strobe and frame read port of the S/PDIF frame FIFO.
interface spdif_frame_fifo_if;
  import spdif_frame_fifo_pkg::*;

  logic [PKG_W-1:0]    package_i;
  logic [2:0]          preamble_i;
  logic                ena_i;
  logic [SAMPLE_W-1:0] left_o;
  logic [SAMPLE_W-1:0] right_o;
  logic [STATUS_W-1:0] status_o;
  logic [IDX_W-1:0]    frame_idx_o;
  logic                valid_o;
  logic                ready_i;

  modport master (
    output package_i, preamble_i, ena_i, ready_i,
    input  left_o, right_o, status_o, frame_idx_o, valid_o
  );

  modport slave (
    input  package_i, preamble_i, ena_i, ready_i,
    output left_o, right_o, status_o, frame_idx_o, valid_o
  );

endinterface

// File: rtl/spdif_frame_fifo_sync_fifo.sv
// Generic synchronous FIFO with occupancy; a write while full is accepted only
// when a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_rd = i_rd_en & ~o_empty;
  assign w_wr = i_wr_en & (~o_full | w_rd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/spdif_frame_fifo.sv
// Pairs channel-A/B subframes into parity-checked stereo frames tagged with
// their channel-status block position, and buffers them for a valid/ready reader.
module spdif_frame_fifo
  import spdif_frame_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   nrst_i,
  spdif_frame_fifo_if.slave      bus,
  input  logic                   clr_cnt_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [CNT_W-1:0]       lost_cnt_o,
  output logic [CNT_W-1:0]       ovf_cnt_o
);

  fsm_t             r_state;
  fsm_t             w_state_nxt;
  logic             w_pre_b;
  logic             w_pre_m;
  logic             w_pre_w;
  logic             w_pre_bad;
  logic             w_cap_a;
  logic             w_wr_b;
  logic             w_lost;
  logic [PKG_W-1:0] r_a_pkg;
  logic [PKG_W-1:0] r_b_pkg_p0;
  logic [IDX_W-1:0] r_idx;
  logic             r_blk;
  logic             r_vld_p0;
  logic             r_vld_p1;
  frame_t           r_frame_p1;
  frame_t           w_head;
  frame_t           w_head_q;
  logic             w_full;
  logic             w_empty;
  logic             w_rd;
  logic             w_ovf;
  logic [CNT_W-1:0] r_lost_cnt;
  logic [CNT_W-1:0] r_ovf_cnt;

  function automatic frame_t build_frame(input logic [PKG_W-1:0] a,
                                         input logic [PKG_W-1:0] b,
                                         input logic [IDX_W-1:0] idx,
                                         input logic             blk);
    frame_t f;
    f.left   = {a[AUDIO_MSB:AUDIO_LSB], a[AUX_MSB:AUX_LSB]};
    f.right  = {b[AUDIO_MSB:AUDIO_LSB], b[AUX_MSB:AUX_LSB]};
    f.status = {blk, sub_perr(b), sub_perr(a),
                b[CHNL_STATUS], a[CHNL_STATUS],
                b[USER_DATA], a[USER_DATA],
                b[VALIDITY], a[VALIDITY]};
    f.idx    = idx;
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_pre_b   = bus.ena_i & (bus.preamble_i == PRE_B);
  assign w_pre_m   = bus.ena_i & (bus.preamble_i == PRE_M);
  assign w_pre_w   = bus.ena_i & (bus.preamble_i == PRE_W);
  assign w_pre_bad = bus.ena_i & ~(w_pre_b | w_pre_m | w_pre_w);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap_a     = 1'b0;
    w_wr_b      = 1'b0;
    w_lost      = w_pre_bad;
    case (r_state)
      ST_IDLE: begin
        if (w_pre_b | w_pre_m) begin
          w_cap_a     = 1'b1;
          w_state_nxt = ST_HAVE_A;
        end else if (w_pre_w) begin
          w_lost = 1'b1;
        end
      end
      ST_HAVE_A: begin
        if (w_pre_w) begin
          w_wr_b      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_pre_b | w_pre_m) begin
          // A new A replaces the orphaned one
          w_cap_a = 1'b1;
          w_lost  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_idx    <= '0;
      r_blk    <= 1'b0;
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p0 <= w_wr_b;
      r_vld_p1 <= r_vld_p0;
      if (w_cap_a) begin
        if (w_pre_b) begin
          r_idx <= '0;
          r_blk <= 1'b1;
        end else begin
          r_idx <= (r_idx == IDX_W'(BLOCK_LEN - 1)) ? '0 : r_idx + 1'b1;
          r_blk <= 1'b0;
        end
      end
    end
  end

  // p0: channel-B package captured; p1: assembled frame waiting for the FIFO write
  always_ff @(posedge clk_i) begin
    if (w_cap_a)  r_a_pkg    <= bus.package_i;
    if (w_wr_b)   r_b_pkg_p0 <= bus.package_i;
    if (r_vld_p0) r_frame_p1 <= build_frame(r_a_pkg, r_b_pkg_p0, r_idx, r_blk);
  end

  sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (clk_i),
    .i_rst_n   (nrst_i),
    .i_wr_en   (r_vld_p1),
    .i_wr_data (r_frame_p1),
    .i_rd_en   (bus.ready_i),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (level_o)
  );

  assign w_rd  = bus.ready_i & ~w_empty;
  assign w_ovf = r_vld_p1 & w_full & ~w_rd;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_lost_cnt <= '0;
      r_ovf_cnt  <= '0;
    end else if (clr_cnt_i) begin
      r_lost_cnt <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      if (w_lost) r_lost_cnt <= sat_inc(r_lost_cnt);
      if (w_ovf)  r_ovf_cnt  <= sat_inc(r_ovf_cnt);
    end
  end

  // Uninitialised storage must not leak out while the FIFO is empty
  assign w_head_q        = w_empty ? '0 : w_head;
  assign bus.left_o      = w_head_q.left;
  assign bus.right_o     = w_head_q.right;
  assign bus.status_o    = w_head_q.status;
  assign bus.frame_idx_o = w_head_q.idx;
  assign bus.valid_o     = ~w_empty;
  assign lost_cnt_o      = r_lost_cnt;
  assign ovf_cnt_o       = r_ovf_cnt;

endmodule

// File: tb/tb_spdif_frame_fifo.sv
// Scoreboard bench for spdif_frame_fifo: directed subframe sequences push
// expected frames; a monitor pops and compares every frame the reader accepts.
module tb_spdif_frame_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [2:0] PB = 3'b001;
  localparam logic [2:0] PM = 3'b010;
  localparam logic [2:0] PW = 3'b100;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] lost_cnt;
  logic [CNT_W-1:0] ovf_cnt;

  spdif_frame_fifo_if ifc ();

  spdif_frame_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i      (clk),
    .nrst_i     (nrst),
    .bus        (ifc),
    .clr_cnt_i  (clr_cnt),
    .level_o    (level),
    .lost_cnt_o (lost_cnt),
    .ovf_cnt_o  (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [8:0]  st;
    logic [7:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [27:0] mk(input logic [23:0] s, input logic v, input logic u,
                                     input logic c, input logic bad);
    logic p;
    p = (^{c, u, v, s}) ^ bad;
    return {p, c, u, v, s};
  endfunction

  task automatic push(input logic [23:0] l, input logic [23:0] r,
                      input logic [8:0] st, input logic [7:0] idx);
    exp_t e;
    e.l = l; e.r = r; e.st = st; e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [2:0] pre, input logic [27:0] pk);
    @(negedge clk);
    ifc.preamble_i = pre;
    ifc.package_i  = pk;
    ifc.ena_i      = 1'b1;
    @(negedge clk);
    ifc.ena_i      = 1'b0;
  endtask

  task automatic pair(input logic [2:0] pa, input logic [23:0] l, input logic [23:0] r,
                      input int idx, input logic blk, input bit keep);
    send(pa, mk(l, 1'b0, 1'b0, 1'b0, 1'b0));
    send(PW, mk(r, 1'b0, 1'b0, 1'b0, 1'b0));
    if (keep) push(l, r, {blk, 8'h00}, 8'(idx));
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    settle(1);
    chk("drain_pending", 32'(exp_q.size()), 0);
    chk("drain_level", 32'(level), 0);
    chk("drain_valid", 32'(ifc.valid_o), 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && ifc.valid_o && ifc.ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL head_unexpected: actual left 0x%0h idx %0d required no frame",
                   ifc.left_o, ifc.frame_idx_o);
        end else begin
          e = exp_q.pop_front();
          if ({ifc.left_o, ifc.right_o, ifc.status_o, ifc.frame_idx_o} !==
              {e.l, e.r, e.st, e.idx}) begin
            errors++;
            $display("FAIL head_frame: actual L=%h R=%h st=%h idx=%0d required L=%h R=%h st=%h idx=%0d",
                     ifc.left_o, ifc.right_o, ifc.status_o, ifc.frame_idx_o,
                     e.l, e.r, e.st, e.idx);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.package_i  = '0;
    ifc.preamble_i = '0;
    ifc.ena_i      = 1'b0;
    ifc.ready_i    = 1'b0;

    // Reset state
    settle(3);
    chk("rst_valid", 32'(ifc.valid_o), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_lost", 32'(lost_cnt), 0);
    chk("rst_ovf", 32'(ovf_cnt), 0);
    chk("rst_left", 32'(ifc.left_o), 0);
    chk("rst_right", 32'(ifc.right_o), 0);
    chk("rst_status", 32'(ifc.status_o), 0);
    chk("rst_idx", 32'(ifc.frame_idx_o), 0);
    @(negedge clk);
    nrst = 1'b1;

    // Basic pair and write latency
    send(PB, mk(24'h123456, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    ifc.preamble_i = PW;
    ifc.package_i  = mk(24'hABCDEF, 1'b0, 1'b0, 1'b0, 1'b0);
    ifc.ena_i      = 1'b1;
    push(24'h123456, 24'hABCDEF, 9'h100, 8'd0);
    @(negedge clk);
    ifc.ena_i = 1'b0;
    #1 chk("lat_n0_valid", 32'(ifc.valid_o), 0);
    settle(1);
    chk("lat_n1_valid", 32'(ifc.valid_o), 0);
    settle(1);
    chk("lat_n2_valid", 32'(ifc.valid_o), 1);
    chk("lat_n2_level", 32'(level), 1);
    @(negedge clk);
    ifc.ready_i = 1'b1;
    wait_drain(20);

    // Full channel-status block and wrap
    pair(PB, 24'h00A000, 24'hF00000, 0, 1'b1, 1'b1);
    for (int i = 1; i < 192; i++)
      pair(PM, 24'(32'h00A000 + i), 24'(32'hF00000 - i * 7), i, 1'b0, 1'b1);
    pair(PM, 24'h5A5A5A, 24'hA5A5A5, 0, 1'b0, 1'b1);
    pair(PB, 24'h0000FF, 24'hFF0000, 0, 1'b1, 1'b1);
    wait_drain(50);

    // Orphaned and unpaired subframes
    chk("lost_before", 32'(lost_cnt), 0);
    send(PW, mk(24'h0F0F0F, 1'b0, 1'b0, 1'b0, 1'b0));
    #1 chk("lost_w_idle", 32'(lost_cnt), 1);
    send(PB, mk(24'h111111, 1'b0, 1'b0, 1'b0, 1'b0));
    send(PB, mk(24'h222222, 1'b0, 1'b0, 1'b0, 1'b0));
    send(PW, mk(24'h333333, 1'b0, 1'b0, 1'b0, 1'b0));
    push(24'h222222, 24'h333333, 9'h100, 8'd0);
    settle(3);
    chk("lost_bbw", 32'(lost_cnt), 2);
    wait_drain(20);

    // Parity error on channel A plus V/U/C placement
    send(PM, mk(24'hC0FFEE, 1'b1, 1'b0, 1'b1, 1'b1));
    send(PW, mk(24'h000BAD, 1'b0, 1'b1, 1'b1, 1'b0));
    push(24'hC0FFEE, 24'h000BAD, 9'h079, 8'd1);
    wait_drain(20);

    // Overflow with a stalled reader
    ifc.ready_i = 1'b0;
    for (int k = 0; k < DEPTH + 3; k++)
      pair(PM, 24'(32'h100 + k), 24'(32'h200000 + k), 2 + k, 1'b0, k < DEPTH);
    settle(3);
    chk("ovf_level", 32'(level), DEPTH);
    chk("ovf_cnt", 32'(ovf_cnt), 3);
    chk("ovf_valid", 32'(ifc.valid_o), 1);
    @(negedge clk);
    ifc.ready_i = 1'b1;
    wait_drain(60);
    chk("ovf_cnt_after", 32'(ovf_cnt), 3);

    // Write into a full FIFO on the same cycle as a read
    ifc.ready_i = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      pair(PM, 24'(32'h300 + k), 24'(32'h400000 + k), 21 + k, 1'b0, 1'b1);
    send(PM, mk(24'h777777, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    ifc.preamble_i = PW;
    ifc.package_i  = mk(24'h888888, 1'b0, 1'b0, 1'b0, 1'b0);
    ifc.ena_i      = 1'b1;
    push(24'h777777, 24'h888888, 9'h000, 8'd37);
    @(negedge clk);
    ifc.ena_i = 1'b0;
    @(negedge clk);
    ifc.ready_i = 1'b1;
    @(negedge clk);
    ifc.ready_i = 1'b0;
    #1;
    chk("rdwr_full_level", 32'(level), DEPTH);
    chk("rdwr_full_ovf", 32'(ovf_cnt), 3);
    @(negedge clk);
    ifc.ready_i = 1'b1;
    wait_drain(60);

    // Invalid preamble, counter clear priority
    send(3'b000, mk(24'h123123, 1'b0, 1'b0, 1'b0, 1'b0));
    #1 chk("lost_bad_pre", 32'(lost_cnt), 3);
    @(negedge clk);
    clr_cnt        = 1'b1;
    ifc.preamble_i = PW;
    ifc.ena_i      = 1'b1;
    @(negedge clk);
    clr_cnt   = 1'b0;
    ifc.ena_i = 1'b0;
    #1;
    chk("clr_prio_lost", 32'(lost_cnt), 0);
    chk("clr_ovf", 32'(ovf_cnt), 0);
    send(PW, mk(24'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    #1 chk("lost_pre_rst", 32'(lost_cnt), 1);

    // Asynchronous reset mid-stream with a held subframe and queued frames
    ifc.ready_i = 1'b0;
    for (int k = 0; k < 3; k++)
      pair(PB, 24'(32'h900 + k), 24'(32'hA00 + k), 0, 1'b1, 1'b1);
    send(PB, mk(24'hDEAD00, 1'b0, 1'b0, 1'b0, 1'b0));
    settle(3);
    chk("prerst_level", 32'(level), 3);
    mon_en = 1'b0;
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("arst_valid", 32'(ifc.valid_o), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_lost", 32'(lost_cnt), 0);
    chk("arst_ovf", 32'(ovf_cnt), 0);
    chk("arst_left", 32'(ifc.left_o), 0);
    exp_q.delete();
    @(negedge clk);
    nrst        = 1'b1;
    mon_en      = 1'b1;
    ifc.ready_i = 1'b1;
    send(PW, mk(24'hBEEF00, 1'b0, 1'b0, 1'b0, 1'b0));
    settle(3);
    chk("post_rst_held_dropped", 32'(lost_cnt), 1);
    chk("post_rst_level", 32'(level), 0);
    pair(PB, 24'h0A0B0C, 24'h0D0E0F, 0, 1'b1, 1'b1);
    wait_drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
